// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared FSM state encoding and counter-width helper for the framed serial receiver
package sipo_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: MSB-first serial-in/parallel-out shift register with async clear
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ShiftEn,
  input  logic             ShiftIn,
  output logic [WIDTH-1:0] ParallelOut
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) ParallelOut <= '0;
    else if (ShiftEn) ParallelOut <= {ParallelOut[WIDTH-2:0], ShiftIn};
endmodule

// File: rtl/sipo_frame_rx_ctrl.sv
// sipo_frame_rx_ctrl: framed serial word receiver with valid/ready output; even parity enabled by SIPO_RX_PARITY_EN
module sipo_frame_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             BitTick,
  input  logic             SerialIn,
  input  logic             DataReady,
  output logic [WIDTH-1:0] DataOut,
  output logic             DataValid,
  output logic             FrameErr,
  output logic             ParityErr,
  output logic             Overrun,
  output logic             Busy
);
  localparam int CW = cnt_w(WIDTH);
`ifdef SIPO_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] sreg;
  logic shift_en, stop_tick, perr, good, accept;
  sipo_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .Clk(Clk), .Reset(Reset), .ShiftEn(shift_en), .ShiftIn(SerialIn), .ParallelOut(sreg)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (BitTick)
      case (state)
        IDLE:    state_n = SerialIn ? IDLE : DATA;
        DATA:    state_n = (count == CW'(WIDTH - 1)) ? AFTER_DATA : DATA;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  always_comb begin
    shift_en  = BitTick && state == DATA;
    stop_tick = BitTick && state == STOP;
    Busy      = state != IDLE;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) count <= '0;
    else if (BitTick && state == IDLE) count <= '0;
    else if (shift_en) count <= count + CW'(1);
`ifdef SIPO_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) par_bit <= 1'b0;
    else if (BitTick && state == PARITY) par_bit <= SerialIn;
  assign perr = ^{sreg, par_bit};
`else
  assign perr = 1'b0;
`endif
  assign good   = stop_tick && SerialIn && !perr;
  assign accept = good && (!DataValid || DataReady);
  // a good word arriving while the previous one is still pending is dropped as an overrun
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      FrameErr  <= 1'b0;
      ParityErr <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      DataOut   <= accept ? sreg : DataOut;
      DataValid <= accept || (DataValid && !DataReady);
      FrameErr  <= stop_tick && !SerialIn;
      ParityErr <= stop_tick && perr;
      Overrun   <= good && DataValid && !DataReady;
    end
endmodule

// File: tb/tb_sipo_frame_rx_ctrl.sv
// tb_sipo_frame_rx_ctrl: directed and random frames checked against a frame-level reference model
module tb_sipo_frame_rx_ctrl;
  logic Clk = 0, Reset = 1, BitTick = 0, SerialIn = 1, DataReady = 0;
  logic [3:0] DataOut;
  logic DataValid, FrameErr, ParityErr, Overrun, Busy;
  int passed = 0, total = 0;
  logic [3:0] exp_out = 0;
  logic exp_valid = 0;

  sipo_frame_rx_ctrl #(.WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .BitTick(BitTick), .SerialIn(SerialIn), .DataReady(DataReady),
    .DataOut(DataOut), .DataValid(DataValid), .FrameErr(FrameErr), .ParityErr(ParityErr),
    .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk); BitTick = 1; SerialIn = b;
    @(negedge Clk); BitTick = 0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ferr"}, FrameErr, 0);
    chk({tag, ".perr"}, ParityErr, 0);
    chk({tag, ".ovr"}, Overrun, 0);
  endtask

  // par_ok=0 sends the wrong parity bit (only meaningful with parity enabled)
  task automatic send_frame(input string tag, input logic [3:0] d, input logic stop,
                            input logic par_ok, input logic rdy);
    logic perr, good, vs, acc;
    DataReady = rdy;
    send_bit(1'b0);
    chk({tag, ".busy"}, Busy, 1);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
`ifdef SIPO_RX_PARITY_EN
    send_bit(par_ok ? ^d : ~^d);
    perr = !par_ok;
`else
    perr = 0;
`endif
    vs   = rdy ? 1'b0 : exp_valid;
    good = stop && !perr;
    acc  = good && !vs;
    if (acc) exp_out = d;
    exp_valid = acc ? 1'b1 : vs;
    @(negedge Clk); BitTick = 1; SerialIn = stop;
    @(negedge Clk); BitTick = 0; SerialIn = 1;
    chk({tag, ".ferr"}, FrameErr, !stop);
    chk({tag, ".perr"}, ParityErr, perr);
    chk({tag, ".ovr"}, Overrun, good && vs);
    chk({tag, ".valid"}, DataValid, exp_valid);
    chk({tag, ".out"}, DataOut, exp_out);
    chk({tag, ".idle"}, Busy, 0);
    @(negedge Clk);
    if (rdy) exp_valid = 0;
    chk_quiet({tag, ".after"});
    chk({tag, ".valid2"}, DataValid, exp_valid);
    chk({tag, ".out2"}, DataOut, exp_out);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst.out", DataOut, 0);
    chk("rst.valid", DataValid, 0);
    chk("rst.busy", Busy, 0);
    chk_quiet("rst");
    Reset = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      chk("idle.busy", Busy, 0);
      chk("idle.valid", DataValid, 0);
      chk_quiet("idle");
    end
    send_frame("f1011", 4'b1011, 1, 1, 1);
    send_frame("ferr", 4'b1100, 0, 1, 1);
    send_frame("fA", 4'hA, 1, 1, 0);
    send_frame("f5ovr", 4'h5, 1, 1, 0);
    DataReady = 1;
    @(negedge Clk);
    exp_valid = 0;
    chk("drain.valid", DataValid, 0);
    chk("drain.out", DataOut, 4'hA);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid.busy", Busy, 1);
    #2 Reset = 1;
    #1;
    chk("arst.busy", Busy, 0);
    chk("arst.out", DataOut, 0);
    chk("arst.valid", DataValid, 0);
    chk_quiet("arst");
    exp_out = 0;
    exp_valid = 0;
    @(negedge Clk); Reset = 0;
    send_frame("f6", 4'h6, 1, 1, 1);
`ifdef SIPO_RX_PARITY_EN
    send_frame("pbad", 4'b0111, 1, 0, 1);
    send_frame("pgood", 4'b0111, 1, 1, 1);
`endif
    for (int n = 0; n < 30; n++)
      send_frame("rnd", 4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
